// File: rtl/pipe_issue.sv
// pipe_issue: in-order instruction issue stage in front of a 3-stage pipeline.
//
// Instructions are queued in a FIFO_DEPTH-entry FIFO and the head is issued at
// most once per clock. With PIPE_ISSUE_HAZARD_EN defined, the head is held
// while either source register matches the destination of a real instruction
// issued in the previous HAZ_DEPTH slots, and each such bubble is counted.
// Without the macro the head issues whenever the queue is non-empty.
//
// Ports:
//   clk1          clock, all state on rising edge
//   rst           synchronous active-high reset
//   in_valid      instruction offered on in_*
//   in_ready      queue can accept (low while rst is high)
//   in_rs1/rs2/rd source A, source B, destination register indices
//   in_func       ALU function code (opaque)
//   in_addr       result memory address (opaque)
//   rs1/rs2/rd    registered issued instruction fields (zero on a bubble)
//   func/addr     registered issued instruction fields (zero on a bubble)
//   issue_valid   outputs carry a real instruction this cycle
//   fifo_count    queue occupancy
//   stall_count   hazard bubble count, saturating at 16'hFFFF
//
// Optional feature macro: PIPE_ISSUE_HAZARD_EN (register hazard handling).
module pipe_issue #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned HAZ_DEPTH  = 2
) (
   input  logic        clk1,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_rs1,
   input  logic [3:0]  in_rs2,
   input  logic [3:0]  in_rd,
   input  logic [1:0]  in_func,
   input  logic [7:0]  in_addr,
   output logic [3:0]  rs1,
   output logic [3:0]  rs2,
   output logic [3:0]  rd,
   output logic [1:0]  func,
   output logic [7:0]  addr,
   output logic        issue_valid,
   output logic [4:0]  fifo_count,
   output logic [15:0] stall_count
);

   localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
   localparam int unsigned InstrW = 22;
   localparam logic [4:0]  DepthC = 5'(FIFO_DEPTH);

   // Entry layout: {rs1, rs2, rd, func, addr}
   logic [InstrW-1:0] mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [4:0]        count_q, count_d;
   logic [InstrW-1:0] out_q, out_d;
   logic              out_vld_q;
   logic [InstrW-1:0] head;
   logic              push, pop, not_empty, hazard;

   assign head      = mem_q[rd_ptr_q];
   assign not_empty = (count_q != 5'd0);

   // Occupancy is taken before any same-cycle pop, so a full queue never
   // accepts even while it is draining.
   assign in_ready  = !rst && (count_q < DepthC);
   assign push      = in_valid && in_ready;
   assign pop       = not_empty && !hazard;

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 5'd1;
         2'b01:   count_d = count_q - 5'd1;
         default: count_d = count_q;
      endcase
      out_d = pop ? head : '0;
   end

   always_ff @(posedge clk1) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         out_q     <= '0;
         out_vld_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         out_q     <= out_d;
         out_vld_q <= pop;
      end
   end

   // Queue storage needs no reset: only entries between the pointers are read.
   always_ff @(posedge clk1) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {in_rs1, in_rs2, in_rd, in_func, in_addr};
      end
   end

`ifdef PIPE_ISSUE_HAZARD_EN
   // Slot 0 holds the most recent issue slot; bubbles enter as invalid.
   logic [HAZ_DEPTH-1:0] sb_vld_q;
   logic [3:0]           sb_rd_q [HAZ_DEPTH];
   logic [15:0]          stall_q, stall_d;
   logic [3:0]           head_rs1, head_rs2, head_rd;

   assign head_rs1 = head[21:18];
   assign head_rs2 = head[17:14];
   assign head_rd  = head[13:10];

   always_comb begin
      hazard = 1'b0;
      for (int unsigned i = 0; i < HAZ_DEPTH; i++) begin
         if (sb_vld_q[i] && ((sb_rd_q[i] == head_rs1) || (sb_rd_q[i] == head_rs2))) begin
            hazard = 1'b1;
         end
      end
   end

   // Only hazard bubbles count; an empty queue is not a stall.
   always_comb begin
      stall_d = stall_q;
      if (not_empty && hazard && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk1) begin
      if (rst) begin
         sb_vld_q <= '0;
         stall_q  <= '0;
         for (int unsigned i = 0; i < HAZ_DEPTH; i++) begin
            sb_rd_q[i] <= '0;
         end
      end else begin
         sb_vld_q[0] <= pop;
         sb_rd_q[0]  <= head_rd;
         for (int unsigned i = 1; i < HAZ_DEPTH; i++) begin
            sb_vld_q[i] <= sb_vld_q[i-1];
            sb_rd_q[i]  <= sb_rd_q[i-1];
         end
         stall_q <= stall_d;
      end
   end

   assign stall_count = stall_q;
`else
   assign hazard      = 1'b0;
   assign stall_count = 16'h0000;
`endif

   assign {rs1, rs2, rd, func, addr} = out_q;
   assign issue_valid                = out_vld_q;
   assign fifo_count                 = count_q;

endmodule

// File: tb/tb_pipe_issue.sv
// tb_pipe_issue: scoreboard bench for pipe_issue. Accepted instructions are
// queued as expected results and popped when the bench's own issue model says
// the head goes out; every clock also checks occupancy, in_ready and the
// bubble counter. Honours PIPE_ISSUE_HAZARD_EN the same way as the design.
module tb_pipe_issue;

   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned HAZ_DEPTH  = 2;

   logic        clk1 = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
   logic [1:0]  in_func = '0;
   logic [7:0]  in_addr = '0;
   logic [3:0]  rs1, rs2, rd;
   logic [1:0]  func;
   logic [7:0]  addr;
   logic        issue_valid;
   logic [4:0]  fifo_count;
   logic [15:0] stall_count;

   always #5 clk1 = ~clk1;

   pipe_issue #(
      .FIFO_DEPTH(FIFO_DEPTH),
      .HAZ_DEPTH (HAZ_DEPTH)
   ) dut (
      .clk1       (clk1),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_rs1     (in_rs1),
      .in_rs2     (in_rs2),
      .in_rd      (in_rd),
      .in_func    (in_func),
      .in_addr    (in_addr),
      .rs1        (rs1),
      .rs2        (rs2),
      .rd         (rd),
      .func       (func),
      .addr       (addr),
      .issue_valid(issue_valid),
      .fifo_count (fifo_count),
      .stall_count(stall_count)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [21:0] exp_q [$];
   logic        sbm_v  [3] = '{1'b0, 1'b0, 1'b0};
   logic [3:0]  sbm_rd [3] = '{4'd0, 4'd0, 4'd0};
   int          exp_stall = 0;
   logic        last_acc = 1'b0;
   logic        last_iv = 1'b0;

   task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                        input logic [1:0] f, input logic [7:0] ad);
      in_valid = 1'b1;
      in_rs1   = a;
      in_rs2   = b;
      in_rd    = d;
      in_func  = f;
      in_addr  = ad;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   // One clock: predict this edge from the model, then check the DUT 1 time unit after it.
   task automatic tick();
      logic        r, acc, haz, exp_iv;
      logic [21:0] cur, head, got;
      int          size_b;
      r      = rst;
      cur    = {in_rs1, in_rs2, in_rd, in_func, in_addr};
      size_b = exp_q.size();
      acc    = in_valid && !r && (size_b < FIFO_DEPTH);
      haz    = 1'b0;
      head   = '0;
      if (size_b > 0) head = exp_q[0];
`ifdef PIPE_ISSUE_HAZARD_EN
      for (int i = 0; i < HAZ_DEPTH; i++) begin
         if (sbm_v[i] && ((sbm_rd[i] == head[21:18]) || (sbm_rd[i] == head[17:14]))) haz = 1'b1;
      end
`endif
      exp_iv = !r && (size_b > 0) && !haz;
      @(posedge clk1);
      #1;
      got = {rs1, rs2, rd, func, addr};
      n_vec++;
      if (issue_valid !== exp_iv) begin
         n_err++;
         $display("FAIL issue_valid t=%0t got %b want %b", $time, issue_valid, exp_iv);
      end
      n_vec++;
      if (got !== (exp_iv ? head : 22'd0)) begin
         n_err++;
         $display("FAIL issue_fields t=%0t got %h want %h", $time, got, exp_iv ? head : 22'd0);
      end
      if (r) begin
         exp_q.delete();
         exp_stall = 0;
         for (int i = 0; i < 3; i++) begin
            sbm_v[i]  = 1'b0;
            sbm_rd[i] = '0;
         end
      end else begin
         if (exp_iv) void'(exp_q.pop_front());
         if (haz && (exp_stall < 16'hFFFF)) exp_stall++;
         for (int i = 2; i > 0; i--) begin
            sbm_v[i]  = sbm_v[i-1];
            sbm_rd[i] = sbm_rd[i-1];
         end
         sbm_v[0]  = exp_iv;
         sbm_rd[0] = head[13:10];
         if (acc) exp_q.push_back(cur);
      end
      last_acc = acc;
      last_iv  = issue_valid;
      n_vec++;
      if (fifo_count !== 5'(exp_q.size())) begin
         n_err++;
         $display("FAIL fifo_count t=%0t got %0d want %0d", $time, fifo_count, exp_q.size());
      end
      n_vec++;
      if (stall_count !== 16'(exp_stall)) begin
         n_err++;
         $display("FAIL stall_count t=%0t got %0d want %0d", $time, stall_count, exp_stall);
      end
      n_vec++;
      if (in_ready !== (!rst && (exp_q.size() < FIFO_DEPTH))) begin
         n_err++;
         $display("FAIL in_ready t=%0t got %b want %b", $time, in_ready,
                  !rst && (exp_q.size() < FIFO_DEPTH));
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(4'hF, 4'hE, 4'hD, 2'd3, 8'hEE);
      tick();
      tick();
      rst = 1'b0;
      idle();
   endtask

   task automatic test_reset();
      do_reset();
      rst = 1'b1;
      drive(4'h1, 4'h2, 4'h3, 2'd1, 8'h11);
      tick();
      tick();
      n_vec++;
      if (in_ready !== 1'b0 || issue_valid !== 1'b0 || fifo_count !== 5'd0
          || stall_count !== 16'd0) begin
         n_err++;
         $display("FAIL reset_state got rdy=%b iv=%b cnt=%0d stall=%0d want 0 0 0 0",
                  in_ready, issue_valid, fifo_count, stall_count);
      end
      rst = 1'b0;
      idle();
      tick();
      n_vec++;
      if (fifo_count !== 5'd0 || issue_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ignored_push got cnt=%0d iv=%b want 0 0", fifo_count, issue_valid);
      end
   endtask

   task automatic test_independent();
      logic [5:0] pat = '0;
      do_reset();
      drive(4'd5, 4'd3, 4'd1, 2'd0, 8'hA0); tick(); pat = {pat[4:0], last_iv};
      drive(4'd6, 4'd4, 4'd2, 2'd1, 8'hA1); tick(); pat = {pat[4:0], last_iv};
      drive(4'd7, 4'd5, 4'd3, 2'd2, 8'hA2); tick(); pat = {pat[4:0], last_iv};
      idle();
      for (int i = 0; i < 3; i++) begin
         tick();
         pat = {pat[4:0], last_iv};
      end
      n_vec++;
      if (pat !== 6'b011100) begin
         n_err++;
         $display("FAIL independent_pattern got %b want 011100", pat);
      end
      n_vec++;
      if (stall_count !== 16'd0) begin
         n_err++;
         $display("FAIL independent_stall got %0d want 0", stall_count);
      end
   endtask

   task automatic test_raw();
      logic [7:0] pat = '0;
      do_reset();
      drive(4'd5, 4'd3, 4'd1, 2'd1, 8'hB0); tick(); pat = {pat[6:0], last_iv};
      drive(4'd1, 4'd4, 4'd2, 2'd2, 8'hB1); tick(); pat = {pat[6:0], last_iv};
      idle();
      for (int i = 0; i < 6; i++) begin
         tick();
         pat = {pat[6:0], last_iv};
      end
`ifdef PIPE_ISSUE_HAZARD_EN
      n_vec++;
      if (pat !== 8'b01001000) begin
         n_err++;
         $display("FAIL raw_pattern got %b want 01001000", pat);
      end
      n_vec++;
      if (stall_count !== 16'd2) begin
         n_err++;
         $display("FAIL raw_stall got %0d want 2", stall_count);
      end
`else
      n_vec++;
      if (pat !== 8'b01100000) begin
         n_err++;
         $display("FAIL raw_pattern got %b want 01100000", pat);
      end
      n_vec++;
      if (stall_count !== 16'd0) begin
         n_err++;
         $display("FAIL raw_stall got %0d want 0", stall_count);
      end
`endif
   endtask

   // Holds the offer until accepted; checks the full-queue view while blocked.
   task automatic offer(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                        input logic [1:0] f, input logic [7:0] ad, inout int dut_max);
      int tries = 0;
      drive(a, b, d, f, ad);
      do begin
         if (exp_q.size() == FIFO_DEPTH) begin
            n_vec++;
            if (in_ready !== 1'b0 || fifo_count !== 5'(FIFO_DEPTH)) begin
               n_err++;
               $display("FAIL full_block got rdy=%b cnt=%0d want 0 %0d",
                        in_ready, fifo_count, FIFO_DEPTH);
            end
         end
         tick();
         if (int'(fifo_count) > dut_max) dut_max = int'(fifo_count);
         tries++;
      end while (!last_acc && tries < 50);
      if (!last_acc) begin
         n_vec++;
         n_err++;
         $display("FAIL offer_timeout got not accepted want accepted within 50 cycles");
      end
      idle();
   endtask

   task automatic test_full_wrap();
      int dut_max = 0;
      int guard = 0;
      do_reset();
      offer(4'd0, 4'd0, 4'd1, 2'd0, 8'h40, dut_max);
      for (int i = 1; i <= 12; i++) begin
         offer(4'd1, 4'(i), 4'd1, 2'(i), 8'(8'h40 + i), dut_max);
      end
      while (exp_q.size() != 0 && guard < 100) begin
         tick();
         guard++;
      end
      n_vec++;
      if (exp_q.size() != 0 || fifo_count !== 5'd0) begin
         n_err++;
         $display("FAIL drain got cnt=%0d want 0", fifo_count);
      end
`ifdef PIPE_ISSUE_HAZARD_EN
      n_vec++;
      if (dut_max != FIFO_DEPTH) begin
         n_err++;
         $display("FAIL full_reached got max %0d want %0d", dut_max, FIFO_DEPTH);
      end
`else
      n_vec++;
      if (dut_max > 1) begin
         n_err++;
         $display("FAIL no_backlog got max %0d want <=1", dut_max);
      end
`endif
   endtask

   task automatic test_mid_reset();
      do_reset();
      drive(4'd0, 4'd0, 4'd2, 2'd0, 8'hC0); tick();
      drive(4'd2, 4'd2, 4'd2, 2'd1, 8'hC1); tick();
      drive(4'd2, 4'd2, 4'd2, 2'd2, 8'hC2); tick();
      drive(4'd2, 4'd2, 4'd2, 2'd3, 8'hC3); tick();
`ifdef PIPE_ISSUE_HAZARD_EN
      n_vec++;
      if (fifo_count !== 5'd3) begin
         n_err++;
         $display("FAIL pre_reset_count got %0d want 3", fifo_count);
      end
`endif
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle();
      n_vec++;
      if (fifo_count !== 5'd0 || issue_valid !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset got cnt=%0d iv=%b want 0 0", fifo_count, issue_valid);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         n_vec++;
         if (issue_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_issue got %b want 0", issue_valid);
         end
      end
      drive(4'd2, 4'd2, 4'd2, 2'd1, 8'hD0);
      tick();
      idle();
      n_vec++;
      if (issue_valid !== 1'b0) begin
         n_err++;
         $display("FAIL no_bypass got %b want 0", issue_valid);
      end
      tick();
      n_vec++;
      if (issue_valid !== 1'b1 || rd !== 4'd2 || addr !== 8'hD0) begin
         n_err++;
         $display("FAIL post_reset_first got iv=%b rd=%0d addr=%h want 1 2 d0",
                  issue_valid, rd, addr);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_independent();
      test_raw();
      test_full_wrap();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
